keypad_scan_ctrl: RTL

Scan controller for a 4x4 matrix keypad: drives active-low column strobes, samples the active-low row lines, debounces over whole scans, rejects ghost/multi-key patterns, and queues press events in a small FIFO. Events go to the consumer (display/LED logic) over a valid/ack handshake. Replaces free-running per-clock column rotation with a paced, debounced front end.

---
 rtl/keypad_scan_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// Paced 4x4 keypad scanner: one column strobed per dwell period, whole-scan
// debounce with ghost rejection, and a small press-event FIFO toward the consumer.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic       key_valid,
   output logic [3:0] key_code,
   input  logic       key_ack,
   output logic       key_held,
   output logic       overflow
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]       DEB_MAX    = 4'(DEBOUNCE_SCANS);
   localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [3:0] {
      C1 = 4'b0111,
      C2 = 4'b1011,
      C3 = 4'b1101,
      C4 = 4'b1110
   } col_state_t;

   col_state_t       state;
   col_state_t       state_next;
   logic             state_legal;
   logic [DIV_W-1:0] dwell;
   logic             last_dwell;
   logic             sample;
   logic             scan_end;
   logic [1:0]       col_idx;

   logic             row_hit;
   logic             row_multi;
   logic [1:0]       row_idx;

   // Per-scan accumulation: hit count saturates at 2, meaning "more than one key".
   logic [1:0]       scan_hits;
   logic [3:0]       scan_code;
   logic [1:0]       hits_now;
   logic [3:0]       code_now;

   logic             cand_key;
   logic [3:0]       cand_code;
   logic [3:0]       deb_cnt;
   logic             acc_key;
   logic [3:0]       acc_code;
   logic             cand_key_next;
   logic [3:0]       cand_code_next;
   logic [3:0]       deb_cnt_next;
   logic             acc_key_next;
   logic [3:0]       acc_code_next;
   logic             res_key;
   logic [3:0]       res_code;
   logic             push;

   logic [3:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   fill;
   logic             full;
   logic             pop;
   logic             do_push;

   assign col        = state;
   assign last_dwell = (dwell == DWELL_LAST);
   assign sample     = last_dwell && state_legal;
   assign scan_end   = sample && (state == C4);

   always_comb begin
      state_next  = state;
      state_legal = 1'b1;
      col_idx     = 2'd0;
      case (state)
         C1: begin col_idx = 2'd0; if (last_dwell) state_next = C2; end
         C2: begin col_idx = 2'd1; if (last_dwell) state_next = C3; end
         C3: begin col_idx = 2'd2; if (last_dwell) state_next = C4; end
         C4: begin col_idx = 2'd3; if (last_dwell) state_next = C1; end
         default: begin
            state_next  = C1;
            state_legal = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= C1;
         dwell <= '0;
      end else begin
         state <= state_next;
         dwell <= (last_dwell || !state_legal) ? '0 : dwell + 1'b1;
      end
   end

   always_comb begin
      row_hit   = 1'b0;
      row_multi = 1'b0;
      row_idx   = 2'd0;
      case (row)
         4'b1111: row_hit = 1'b0;
         4'b0111: begin row_hit = 1'b1; row_idx = 2'd0; end
         4'b1011: begin row_hit = 1'b1; row_idx = 2'd1; end
         4'b1101: begin row_hit = 1'b1; row_idx = 2'd2; end
         4'b1110: begin row_hit = 1'b1; row_idx = 2'd3; end
         default: row_multi = 1'b1;
      endcase
   end

   always_comb begin
      hits_now = scan_hits;
      code_now = scan_code;
      if (row_multi) begin
         hits_now = 2'd2;
      end else if (row_hit) begin
         if (scan_hits == 2'd0) begin
            hits_now = 2'd1;
            code_now = {row_idx, col_idx};
         end else begin
            hits_now = 2'd2;
         end
      end
   end

   // An illegal column state restarts the scan so a partial result never leaks through.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_hits <= 2'd0;
         scan_code <= 4'd0;
      end else if (!state_legal || scan_end) begin
         scan_hits <= 2'd0;
         scan_code <= 4'd0;
      end else if (sample) begin
         scan_hits <= hits_now;
         scan_code <= code_now;
      end
   end

   // NONE is carried as key=0 with code 0 so candidate/accepted compare as plain vectors.
   always_comb begin
      cand_key_next  = cand_key;
      cand_code_next = cand_code;
      deb_cnt_next   = deb_cnt;
      acc_key_next   = acc_key;
      acc_code_next  = acc_code;
      res_key        = (hits_now == 2'd1);
      res_code       = (hits_now == 2'd1) ? code_now : 4'd0;
      push           = 1'b0;
      if (scan_end && hits_now != 2'd2) begin
         if (res_key == cand_key && res_code == cand_code) begin
            if (deb_cnt < DEB_MAX) deb_cnt_next = deb_cnt + 1'b1;
         end else begin
            cand_key_next  = res_key;
            cand_code_next = res_code;
            deb_cnt_next   = 4'd1;
         end
         if (deb_cnt_next == DEB_MAX &&
             (cand_key_next != acc_key || cand_code_next != acc_code)) begin
            acc_key_next  = cand_key_next;
            acc_code_next = cand_code_next;
            push          = cand_key_next;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cand_key  <= 1'b0;
         cand_code <= 4'd0;
         deb_cnt   <= 4'd0;
         acc_key   <= 1'b0;
         acc_code  <= 4'd0;
      end else begin
         cand_key  <= cand_key_next;
         cand_code <= cand_code_next;
         deb_cnt   <= deb_cnt_next;
         acc_key   <= acc_key_next;
         acc_code  <= acc_code_next;
      end
   end

   assign key_held  = acc_key;
   assign full      = (fill == FIFO_FULL);
   assign key_valid = (fill != '0);
   assign pop       = key_valid && key_ack;
   assign do_push   = push && (!full || pop);
   assign key_code  = key_valid ? mem[rd_ptr] : 4'd0;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= acc_code_next;
   end

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fill     <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
         if (push && full && !pop) overflow <= 1'b1;
      end
   end

endmodule
